// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared control-step states, opcodes and strobe bundle
package cpu_ctrl_pkg;

  localparam int OPC_W     = 5;
  localparam int REG_SEL_W = 4;

  localparam logic [4:0] OPC_NEG = 5'b10001;
  localparam logic [4:0] OPC_NOT = 5'b10010;

  typedef enum logic [2:0] {
    IDLE,
    T0,
    T1,
    T2,
    DEC,
    T3,
    T4
  } state_e;

  // Single-bit control outputs, registered together as one word.
  typedef struct packed {
    logic pc_out;
    logic mar_in;
    logic inc_pc;
    logic z_in;
    logic zlow_out;
    logic pc_in;
    logic mem_read;
    logic mdr_in;
    logic mdr_out;
    logic ir_in;
    logic gpr_out_en;
    logic gpr_in_en;
    logic done;
    logic busy;
    logic illegal;
  } strobe_t;

  function automatic logic is_unary_op(input logic [4:0] opc);
    return (opc == OPC_NEG) || (opc == OPC_NOT);
  endfunction

endpackage

// File: rtl/unary_op_sequencer.sv
// rtl/unary_op_sequencer.sv - fetch/execute control steps for NEG and NOT
// Optional memory-wait timeout: define UNARY_OP_SEQ_TIMEOUT_EN.
module unary_op_sequencer #(
  parameter int OPC_W        = cpu_ctrl_pkg::OPC_W,
  parameter int REG_SEL_W    = cpu_ctrl_pkg::REG_SEL_W,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic                 clock,
  input  logic                 clear_n,
  input  logic                 start,
  input  logic                 mem_rdy,
  input  logic [OPC_W-1:0]     ir_opcode,
  input  logic [REG_SEL_W-1:0] ir_ra,
  input  logic [REG_SEL_W-1:0] ir_rb,
  output logic                 pc_out,
  output logic                 mar_in,
  output logic                 inc_pc,
  output logic                 z_in,
  output logic                 zlow_out,
  output logic                 pc_in,
  output logic                 mem_read,
  output logic                 mdr_in,
  output logic                 mdr_out,
  output logic                 ir_in,
  output logic                 gpr_out_en,
  output logic [REG_SEL_W-1:0] gpr_out_sel,
  output logic                 gpr_in_en,
  output logic [REG_SEL_W-1:0] gpr_in_sel,
  output logic [OPC_W-1:0]     alu_op,
  output logic                 busy,
  output logic                 done,
  output logic                 illegal
);

  import cpu_ctrl_pkg::*;

  if (MEM_WAIT_MAX < 1) begin : g_bad_wait_max
    $error("MEM_WAIT_MAX must be at least 1");
  end

  state_e               state_q, state_d;
  logic [REG_SEL_W-1:0] ra_q, ra_d;
  logic [REG_SEL_W-1:0] rb_q, rb_d;
  logic [OPC_W-1:0]     op_q, op_d;
  strobe_t              strb_q, strb_d;
  logic [REG_SEL_W-1:0] out_sel_q, out_sel_d;
  logic [REG_SEL_W-1:0] in_sel_q, in_sel_d;
  logic [OPC_W-1:0]     alu_op_q, alu_op_d;
  logic                 illegal_d;

`ifdef UNARY_OP_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(MEM_WAIT_MAX + 1);
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
`endif

  always_comb begin
    state_d   = state_q;
    ra_d      = ra_q;
    rb_d      = rb_q;
    op_d      = op_q;
    illegal_d = 1'b0;
    unique case (state_q)
      IDLE: if (start) state_d = T0;
      T0:   state_d = T1;
      T1: begin
        if (mem_rdy) begin
          state_d = T2;
        end
`ifdef UNARY_OP_SEQ_TIMEOUT_EN
        // Count includes the current T1 cycle, so this fires after MEM_WAIT_MAX cycles.
        else if (wait_cnt_q == CNT_W'(MEM_WAIT_MAX - 1)) begin
          state_d   = IDLE;
          illegal_d = 1'b1;
        end
`endif
      end
      T2:   state_d = DEC;
      DEC: begin
        if (is_unary_op(5'(ir_opcode))) begin
          ra_d    = ir_ra;
          rb_d    = ir_rb;
          op_d    = ir_opcode;
          state_d = T3;
        end else begin
          state_d   = IDLE;
          illegal_d = 1'b1;
        end
      end
      T3:      state_d = T4;
      T4:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef UNARY_OP_SEQ_TIMEOUT_EN
  always_comb begin
    wait_cnt_d = '0;
    if (state_q == T1 && state_d == T1) wait_cnt_d = wait_cnt_q + 1'b1;
  end
`endif

  // Outputs are decoded from the next state so they are registered and
  // valid for the entire cycle spent in that state.
  always_comb begin
    strb_d            = '0;
    strb_d.pc_out     = (state_d == T0);
    strb_d.mar_in     = (state_d == T0);
    strb_d.inc_pc     = (state_d == T0);
    strb_d.z_in       = (state_d == T0) || (state_d == T3);
    strb_d.zlow_out   = (state_d == T1) || (state_d == T4);
    strb_d.pc_in      = (state_d == T1) && (state_q != T1);
    strb_d.mem_read   = (state_d == T1);
    strb_d.mdr_in     = (state_d == T1);
    strb_d.mdr_out    = (state_d == T2);
    strb_d.ir_in      = (state_d == T2);
    strb_d.gpr_out_en = (state_d == T3);
    strb_d.gpr_in_en  = (state_d == T4);
    strb_d.done       = (state_d == T4);
    strb_d.busy       = (state_d != IDLE);
    strb_d.illegal    = illegal_d;
    out_sel_d         = (state_d == T3) ? rb_d : '0;
    in_sel_d          = (state_d == T4) ? ra_d : '0;
    alu_op_d          = (state_d == T3) ? op_d : '0;
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q   <= IDLE;
      ra_q      <= '0;
      rb_q      <= '0;
      op_q      <= '0;
      strb_q    <= '0;
      out_sel_q <= '0;
      in_sel_q  <= '0;
      alu_op_q  <= '0;
    end else begin
      state_q   <= state_d;
      ra_q      <= ra_d;
      rb_q      <= rb_d;
      op_q      <= op_d;
      strb_q    <= strb_d;
      out_sel_q <= out_sel_d;
      in_sel_q  <= in_sel_d;
      alu_op_q  <= alu_op_d;
    end
  end

`ifdef UNARY_OP_SEQ_TIMEOUT_EN
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) wait_cnt_q <= '0;
    else          wait_cnt_q <= wait_cnt_d;
  end
`endif

  assign pc_out      = strb_q.pc_out;
  assign mar_in      = strb_q.mar_in;
  assign inc_pc      = strb_q.inc_pc;
  assign z_in        = strb_q.z_in;
  assign zlow_out    = strb_q.zlow_out;
  assign pc_in       = strb_q.pc_in;
  assign mem_read    = strb_q.mem_read;
  assign mdr_in      = strb_q.mdr_in;
  assign mdr_out     = strb_q.mdr_out;
  assign ir_in       = strb_q.ir_in;
  assign gpr_out_en  = strb_q.gpr_out_en;
  assign gpr_in_en   = strb_q.gpr_in_en;
  assign done        = strb_q.done;
  assign busy        = strb_q.busy;
  assign illegal     = strb_q.illegal;
  assign gpr_out_sel = out_sel_q;
  assign gpr_in_sel  = in_sel_q;
  assign alu_op      = alu_op_q;

endmodule

// File: tb/tb_unary_op_sequencer.sv
// tb/tb_unary_op_sequencer.sv - directed self-checking bench for unary_op_sequencer
module tb_unary_op_sequencer;

  // pc,mar,inc,z | zlow,pcin,mrd,mdrin | mdrout,irin,gout,gin | done,busy,ill
  localparam logic [14:0] S_IDLE = 15'b0000_0000_0000_000;
  localparam logic [14:0] S_T0   = 15'b1111_0000_0000_010;
  localparam logic [14:0] S_T1F  = 15'b0000_1111_0000_010;
  localparam logic [14:0] S_T1W  = 15'b0000_1011_0000_010;
  localparam logic [14:0] S_T2   = 15'b0000_0000_1100_010;
  localparam logic [14:0] S_DEC  = 15'b0000_0000_0000_010;
  localparam logic [14:0] S_T3   = 15'b0001_0000_0010_010;
  localparam logic [14:0] S_T4   = 15'b0000_1000_0001_110;
  localparam logic [14:0] S_ILL  = 15'b0000_0000_0000_001;

  logic       clock = 1'b0;
  logic       clear_n;
  logic       start;
  logic       mem_rdy;
  logic [4:0] ir_opcode;
  logic [3:0] ir_ra, ir_rb;
  logic pc_out, mar_in, inc_pc, z_in, zlow_out, pc_in, mem_read, mdr_in, mdr_out, ir_in;
  logic gpr_out_en, gpr_in_en, busy, done, illegal;
  logic [3:0] gpr_out_sel, gpr_in_sel;
  logic [4:0] alu_op;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clock = ~clock;

  unary_op_sequencer dut (
    .clock(clock), .clear_n(clear_n), .start(start), .mem_rdy(mem_rdy),
    .ir_opcode(ir_opcode), .ir_ra(ir_ra), .ir_rb(ir_rb),
    .pc_out(pc_out), .mar_in(mar_in), .inc_pc(inc_pc), .z_in(z_in),
    .zlow_out(zlow_out), .pc_in(pc_in), .mem_read(mem_read), .mdr_in(mdr_in),
    .mdr_out(mdr_out), .ir_in(ir_in), .gpr_out_en(gpr_out_en),
    .gpr_out_sel(gpr_out_sel), .gpr_in_en(gpr_in_en), .gpr_in_sel(gpr_in_sel),
    .alu_op(alu_op), .busy(busy), .done(done), .illegal(illegal)
  );

  wire [14:0] obs = {pc_out, mar_in, inc_pc, z_in, zlow_out, pc_in, mem_read, mdr_in,
                     mdr_out, ir_in, gpr_out_en, gpr_in_en, done, busy, illegal};
  wire [12:0] sels = {gpr_out_sel, gpr_in_sel, alu_op};

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    clear_n = 1'b0;
    start   = 1'b0;
    tick();
    clear_n = 1'b1;
    tick();
  endtask

  initial begin
    clear_n = 1'b0; start = 1'b0; mem_rdy = 1'b0;
    ir_opcode = '0; ir_ra = '0; ir_rb = '0;
    #12;
    check("reset_strobes", 32'(obs), 32'(S_IDLE));
    check("reset_sels", 32'(sels), 32'h0);
    clear_n = 1'b1;
    tick();

    // NEG with memory ready immediately; start held through T3/T4 must be ignored.
    ir_opcode = 5'b10001; ir_ra = 4'd3; ir_rb = 4'd5; mem_rdy = 1'b1;
    start = 1'b1; cyc = 0;
    tick(); start = 1'b0;
    check("neg_t0", 32'(obs), 32'(S_T0));
    tick(); check("neg_t1", 32'(obs), 32'(S_T1F));
    tick(); check("neg_t2", 32'(obs), 32'(S_T2));
    tick(); check("neg_dec", 32'(obs), 32'(S_DEC));
    tick(); check("neg_t3", 32'(obs), 32'(S_T3));
    check("neg_t3_outsel", 32'(gpr_out_sel), 32'd5);
    check("neg_t3_aluop", 32'(alu_op), 32'h11);
    start = 1'b1;
    tick(); check("neg_t4", 32'(obs), 32'(S_T4));
    check("neg_t4_insel", 32'(gpr_in_sel), 32'd3);
    check("neg_done_cycle", 32'(cyc), 32'd6);
    tick(); start = 1'b0;
    check("neg_idle_start_ignored", 32'(obs), 32'(S_IDLE));
    check("neg_idle_sels", 32'(sels), 32'h0);
    tick();

    // NOT with four wait cycles in T1.
    ir_opcode = 5'b10010; ir_ra = 4'd9; ir_rb = 4'd2; mem_rdy = 1'b0;
    start = 1'b1; cyc = 0;
    tick(); start = 1'b0;
    check("not_t0", 32'(obs), 32'(S_T0));
    tick(); check("not_t1_first", 32'(obs), 32'(S_T1F));
    for (int i = 0; i < 4; i++) begin
      tick(); check("not_t1_wait", 32'(obs), 32'(S_T1W));
    end
    mem_rdy = 1'b1;
    tick(); check("not_t2", 32'(obs), 32'(S_T2));
    tick(); check("not_dec", 32'(obs), 32'(S_DEC));
    tick(); check("not_t3", 32'(obs), 32'(S_T3));
    check("not_t3_sels", 32'(sels), {19'h0, 4'd2, 4'd0, 5'b10010});
    tick(); check("not_t4", 32'(obs), 32'(S_T4));
    check("not_done_cycle", 32'(cyc), 32'd10);
    tick(); check("not_idle", 32'(obs), 32'(S_IDLE));

    // Illegal opcode: illegal pulse after DEC, no execute steps, no done.
    ir_opcode = 5'b00011; mem_rdy = 1'b1;
    start = 1'b1;
    tick(); start = 1'b0;
    check("ill_t0", 32'(obs), 32'(S_T0));
    tick(); tick();
    check("ill_t2", 32'(obs), 32'(S_T2));
    tick(); check("ill_dec", 32'(obs), 32'(S_DEC));
    tick(); check("ill_pulse", 32'(obs), 32'(S_ILL));
    check("ill_sels", 32'(sels), 32'h0);
    tick(); check("ill_after", 32'(obs), 32'(S_IDLE));

    // Asynchronous reset during T3, then a clean sequence with extreme selects.
    ir_opcode = 5'b10001; ir_ra = 4'd1; ir_rb = 4'd2;
    start = 1'b1;
    tick(); start = 1'b0;
    repeat (4) tick();
    check("rst_pre_t3", 32'(obs), 32'(S_T3));
    #2 clear_n = 1'b0;
    #1;
    check("rst_async_strobes", 32'(obs), 32'(S_IDLE));
    check("rst_async_sels", 32'(sels), 32'h0);
    #1 clear_n = 1'b1;
    tick(); check("rst_stays_idle", 32'(obs), 32'(S_IDLE));
    ir_ra = 4'd0; ir_rb = 4'd15;
    start = 1'b1;
    tick(); start = 1'b0;
    repeat (4) tick();
    check("rst_new_t3", 32'(obs), 32'(S_T3));
    check("rst_new_outsel", 32'(gpr_out_sel), 32'd15);
    tick(); check("rst_new_t4", 32'(obs), 32'(S_T4));
    check("rst_new_insel", 32'(gpr_in_sel), 32'd0);
    tick();

    // Same source and destination register.
    ir_opcode = 5'b10010; ir_ra = 4'd7; ir_rb = 4'd7;
    start = 1'b1;
    tick(); start = 1'b0;
    repeat (4) tick();
    check("same_t3_outsel", 32'(gpr_out_sel), 32'd7);
    tick(); check("same_t4_insel", 32'(gpr_in_sel), 32'd7);
    check("same_t4", 32'(obs), 32'(S_T4));
    tick();

    // Random traffic: bus source exclusivity and done/illegal exclusivity.
    for (int i = 0; i < 3000; i++) begin
      start   = ($urandom_range(0, 3) == 0);
      mem_rdy = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 2))
        0:       ir_opcode = 5'b10001;
        1:       ir_opcode = 5'b10010;
        default: ir_opcode = 5'($urandom_range(0, 31));
      endcase
      ir_ra = 4'($urandom_range(0, 15));
      ir_rb = 4'($urandom_range(0, 15));
      tick();
      check("bus_one_source", 32'($countones({pc_out, zlow_out, mdr_out, gpr_out_en}) <= 1), 32'd1);
      check("done_illegal_excl", 32'(done & illegal), 32'd0);
    end
    do_reset();

    // Memory never ready.
    ir_opcode = 5'b10001; mem_rdy = 1'b0;
    start = 1'b1;
    tick(); start = 1'b0;
    check("to_t0", 32'(obs), 32'(S_T0));
    tick(); check("to_t1_first", 32'(obs), 32'(S_T1F));
    for (int i = 0; i < 14; i++) begin
      tick(); check("to_t1_wait", 32'(obs), 32'(S_T1W));
    end
    tick();
`ifdef UNARY_OP_SEQ_TIMEOUT_EN
    check("to_expire", 32'(obs), 32'(S_ILL));
    tick(); check("to_after", 32'(obs), 32'(S_IDLE));
`else
    check("to_still_waiting", 32'(obs), 32'(S_T1W));
    repeat (10) tick();
    check("to_still_waiting_late", 32'(obs), 32'(S_T1W));
`endif
    do_reset();
    check("final_idle", 32'(obs), 32'(S_IDLE));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
